// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction fetcher in front of a small in-order
// queue feeding decode. The ROM is registered, so a word requested in one cycle
// returns in the next and is pushed into the queue then. Fetch credit counts both
// queued entries and the single in-flight request, which keeps the queue from
// ever overflowing without a separate full check.
//
// Build option: define IFQ_JAL_PREDICT_EN to predict JAL instructions as taken
// at push time. Without it every word is fetched sequentially and
// ifq_pred_taken is tied low.
module instr_fetch_queue #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic [ADDR_WIDTH-1:0] iaddr,
  input  logic [SIZE-1:0]       idata,
  output logic                  ifq_valid,
  input  logic                  ifq_ready,
  output logic [SIZE-1:0]       ifq_inst,
  output logic [ADDR_WIDTH-1:0] ifq_pc,
  output logic                  ifq_pred_taken,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [SIZE-1:0]       NOP_INST = SIZE'(32'h0000_0013);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

  // Fetch-side state: next PC to request and the request currently in flight
  logic [ADDR_WIDTH-1:0] fetchPc_q, fetchPc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflightTag_q, inflightTag_d;
  logic                  inflightKill_q, inflightKill_d;

  // Queue bookkeeping
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;

  // Queue storage
  logic [SIZE-1:0]       memInst [DEPTH];
  logic [ADDR_WIDTH-1:0] memPc   [DEPTH];

  logic [CNT_W:0]        occupancy;
  logic                  issueEn;
  logic                  pushEn;
  logic                  popEn;
  logic                  jalTaken;
  logic [ADDR_WIDTH-1:0] predTarget;
  logic [ADDR_WIDTH-1:0] redirectTarget;
  logic                  unusedRedirectLsbs;

  // The ROM is word addressed; the byte PC's low two bits never reach it
  assign iaddr = {2'b00, fetchPc_q[ADDR_WIDTH-1:2]};

  // Restart addresses are forced onto a word boundary; the dropped bits are
  // deliberately ignored
  assign redirectTarget     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unusedRedirectLsbs = ^redirect_pc[1:0];

  // A new request is allowed only if every queued word plus the one in flight
  // still leaves room; a pop this cycle is not counted as free space yet
  assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
  assign issueEn   = ~redirect & (occupancy < (CNT_W+1)'(DEPTH));

  // The returning word is kept unless it was killed or a redirect flushes it
  assign pushEn = inflight_q & ~inflightKill_q & ~redirect;
  assign popEn  = ifq_valid & ifq_ready & ~redirect;

`ifdef IFQ_JAL_PREDICT_EN
  logic                  isJal;
  logic                  pushPred;
  logic [20:0]           jImm;
  logic                  memPred [DEPTH];

  // Decode the returning word as a JAL and form its target from the fetch tag
  always_comb begin
    isJal          = (idata[6:0] == 7'b1101111);
    jImm           = {idata[31], idata[19:12], idata[20], idata[30:21], 1'b0};
    predTarget     = inflightTag_q + ADDR_WIDTH'($signed(jImm));
    predTarget[1:0] = 2'b00;
  end

  assign jalTaken = pushEn & isJal;
  assign pushPred = isJal;

  // Remember which queued entries were predicted taken
  always_ff @(posedge CLK) begin
    if (pushEn) begin
      memPred[wrPtr_q] <= pushPred;
    end
  end

  assign ifq_pred_taken = ifq_valid & memPred[rdPtr_q];
`else
  assign jalTaken       = 1'b0;
  assign predTarget     = '0;
  assign ifq_pred_taken = 1'b0;
`endif

  // Next fetch PC and in-flight tracking; redirect beats prediction, which
  // beats sequential advance
  always_comb begin
    fetchPc_d      = fetchPc_q;
    inflight_d     = issueEn;
    inflightTag_d  = inflightTag_q;
    inflightKill_d = issueEn & jalTaken;
    if (issueEn) begin
      fetchPc_d     = fetchPc_q + PC_STEP;
      inflightTag_d = fetchPc_q;
    end
    if (jalTaken) begin
      fetchPc_d = predTarget;
    end
    if (redirect) begin
      fetchPc_d = redirectTarget;
    end
  end

  // Queue pointer and occupancy update; a redirect empties the queue outright
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (redirect) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushEn) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (popEn) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      case ({pushEn, popEn})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetchPc_q      <= '0;
      inflight_q     <= 1'b0;
      inflightTag_q  <= '0;
      inflightKill_q <= 1'b0;
      count_q        <= '0;
      wrPtr_q        <= '0;
      rdPtr_q        <= '0;
    end else begin
      fetchPc_q      <= fetchPc_d;
      inflight_q     <= inflight_d;
      inflightTag_q  <= inflightTag_d;
      inflightKill_q <= inflightKill_d;
      count_q        <= count_d;
      wrPtr_q        <= wrPtr_d;
      rdPtr_q        <= rdPtr_d;
    end
  end

  // Queue storage needs no reset; the count alone decides what is visible
  always_ff @(posedge CLK) begin
    if (pushEn) begin
      memInst[wrPtr_q] <= idata;
      memPc[wrPtr_q]   <= inflightTag_q;
    end
  end

  // Head of queue toward decode; an empty queue presents a NOP at PC 0
  always_comb begin
    ifq_valid = (count_q != '0);
    ifq_inst  = NOP_INST;
    ifq_pc    = '0;
    if (ifq_valid) begin
      ifq_inst = memInst[rdPtr_q];
      ifq_pc   = memPc[rdPtr_q];
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Testbench for instr_fetch_queue: directed scenarios with a queue-based
// reference model compared every cycle, plus literal PC sequences.
module tb_instr_fetch_queue;

  localparam int SIZE  = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam logic [31:0] JAL_PLUS_20 = 32'h0200_006F;

  logic            CLK;
  logic            RESET;
  logic [AW-1:0]   iaddr;
  logic [SIZE-1:0] idata;
  logic            ifq_valid;
  logic            ifq_ready;
  logic [SIZE-1:0] ifq_inst;
  logic [AW-1:0]   ifq_pc;
  logic            ifq_pred_taken;
  logic            redirect;
  logic [AW-1:0]   redirect_pc;

  typedef struct {
    logic [31:0]   inst;
    logic [AW-1:0] pc;
    logic          pred;
  } entry_t;

  logic [31:0] rom [256];

  // Reference model state: queued entries in fetch order and the pending fetch
  entry_t mFifo[$];
  int     mFetchPc;
  bit     mInflight;
  int     mTag;
  bit     mKill;

  // Delivered-entry log and the first-valid measurement since reset release
  logic [AW-1:0] logPc[$];
  logic          logPred[$];
  int            sinceRelease;
  int            firstValid;

  int compared;
  int mismatched;

  instr_fetch_queue #(
    .SIZE(SIZE),
    .ADDR_WIDTH(AW),
    .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .iaddr(iaddr),
    .idata(idata),
    .ifq_valid(ifq_valid),
    .ifq_ready(ifq_ready),
    .ifq_inst(ifq_inst),
    .ifq_pc(ifq_pc),
    .ifq_pred_taken(ifq_pred_taken),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Registered ROM: the word for the address seen at an edge appears after it
  always @(posedge CLK) begin
    idata <= rom[iaddr[7:0]];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance the reference model by one clock edge using pre-edge inputs
  task automatic modelStep();
    int     occ;
    bit     issue;
    bit     pushIt;
    bit     popIt;
    bit     jal;
    int     target;
    int     imm;
    logic [20:0] imm21;
    entry_t e;
    if (RESET) begin
      mFifo.delete();
      mFetchPc  = 0;
      mInflight = 0;
      mTag      = 0;
      mKill     = 0;
      return;
    end
    occ    = mFifo.size() + (mInflight ? 1 : 0);
    issue  = !redirect && (occ < DEPTH);
    pushIt = mInflight && !mKill && !redirect;
    popIt  = (mFifo.size() > 0) && ifq_ready && !redirect;
    jal    = 0;
    target = 0;
    if (redirect) begin
      mFifo.delete();
      mFetchPc  = int'(redirect_pc) & 'h3FC;
      mInflight = 0;
      mKill     = 0;
      return;
    end
    if (popIt) begin
      void'(mFifo.pop_front());
    end
    if (pushIt) begin
      e.inst = idata;
      e.pc   = AW'(mTag);
      e.pred = 1'b0;
`ifdef IFQ_JAL_PREDICT_EN
      if (idata[6:0] == 7'b1101111) begin
        imm21 = {idata[31], idata[19:12], idata[20], idata[30:21], 1'b0};
        imm   = int'(imm21);
        if (imm21[20]) imm = imm - (1 << 21);
        target = (mTag + imm) & 'h3FC;
        e.pred = 1'b1;
        jal    = 1;
      end
`else
      imm21 = '0;
      imm   = 0;
`endif
      mFifo.push_back(e);
    end
    mKill     = issue && jal;
    mInflight = issue;
    if (issue) mTag = mFetchPc;
    if (jal) mFetchPc = target;
    else if (issue) mFetchPc = (mFetchPc + 4) % (1 << AW);
  endtask

  // Model runs on every rising edge
  initial begin
    mFetchPc  = 0;
    mInflight = 0;
    mTag      = 0;
    mKill     = 0;
    forever begin
      @(posedge CLK);
      modelStep();
    end
  end

  // Per-cycle compare on the falling edge, plus delivery logging
  initial begin
    sinceRelease = 0;
    firstValid   = -1;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        checkOutput("rstValid", 32'(ifq_valid), 32'd0);
        checkOutput("rstInst", ifq_inst, 32'h13);
        checkOutput("rstPc", 32'(ifq_pc), 32'd0);
        checkOutput("rstIaddr", 32'(iaddr), 32'd0);
        sinceRelease = 0;
        firstValid   = -1;
      end else begin
        if (mFifo.size() > 0) begin
          checkOutput("valid", 32'(ifq_valid), 32'd1);
          checkOutput("inst", ifq_inst, mFifo[0].inst);
          checkOutput("pc", 32'(ifq_pc), 32'(mFifo[0].pc));
          checkOutput("pred", 32'(ifq_pred_taken), 32'(mFifo[0].pred));
        end else begin
          checkOutput("valid", 32'(ifq_valid), 32'd0);
          checkOutput("inst", ifq_inst, 32'h13);
          checkOutput("pc", 32'(ifq_pc), 32'd0);
          checkOutput("pred", 32'(ifq_pred_taken), 32'd0);
        end
        checkOutput("iaddr", 32'(iaddr), 32'(mFetchPc >> 2));
        if (ifq_valid && firstValid < 0) firstValid = sinceRelease;
        sinceRelease++;
        if (ifq_valid && ifq_ready && !redirect) begin
          logPc.push_back(ifq_pc);
          logPred.push_back(ifq_pred_taken);
        end
      end
    end
  end

  // Drive inputs just after an edge and hold them for n cycles
  task automatic applyStimulus(input logic rdy, input logic redir, input logic [AW-1:0] rpc, input int n);
    ifq_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Assert reset mid-cycle, confirm the outputs drop at once, then release
  task automatic doReset(input logic readyAfter);
    @(posedge CLK);
    #1;
    RESET       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    ifq_ready   = readyAfter;
    #1;
    checkOutput("asyncRstValid", 32'(ifq_valid), 32'd0);
    checkOutput("asyncRstInst", ifq_inst, 32'h13);
    checkOutput("asyncRstPc", 32'(ifq_pc), 32'd0);
    checkOutput("asyncRstIaddr", 32'(iaddr), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    logPc.delete();
    logPred.delete();
  endtask

  task automatic checkPcLog(input string name, input int idx, input logic [31:0] expected);
    logic [31:0] act;
    act = (idx < logPc.size()) ? 32'(logPc[idx]) : 32'hDEAD_BEEF;
    checkOutput($sformatf("%s%0d", name, idx), act, expected);
  endtask

  task automatic checkPredLog(input string name, input int idx, input logic [31:0] expected);
    logic [31:0] act;
    act = (idx < logPred.size()) ? 32'(logPred[idx]) : 32'hDEAD_BEEF;
    checkOutput($sformatf("%s%0d", name, idx), act, expected);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin
    int expA[5];
    int expB[6];
    int expC[7];
    compared    = 0;
    mismatched  = 0;
    RESET       = 1'b1;
    ifq_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    for (int k = 0; k < 256; k++) rom[k] = 32'(k);

    // Streaming from reset: first valid two cycles after release
    doReset(1'b1);
    applyStimulus(1'b1, 1'b0, '0, 10);
    checkOutput("t1FirstValid", 32'(firstValid), 32'd2);
    expA = '{'h000, 'h004, 'h008, 'h00C, 'h010};
    for (int i = 0; i < 5; i++) checkPcLog("t1Pc", i, 32'(expA[i]));

    // Decode stalled: queue fills to four, fetch address freezes at word 4
    doReset(1'b0);
    applyStimulus(1'b0, 1'b0, '0, 8);
    checkOutput("t2Valid", 32'(ifq_valid), 32'd1);
    checkOutput("t2Iaddr", 32'(iaddr), 32'd4);
    checkOutput("t2HeadPc", 32'(ifq_pc), 32'd0);
    applyStimulus(1'b1, 1'b0, '0, 10);
    for (int i = 0; i < 5; i++) checkPcLog("t2Pc", i, 32'(expA[i]));

    // Redirect to a misaligned address with three entries queued
    doReset(1'b0);
    applyStimulus(1'b0, 1'b0, '0, 4);
    applyStimulus(1'b0, 1'b1, 10'h3FE, 1);
    checkOutput("t3ValidAfterRedirect", 32'(ifq_valid), 32'd0);
    checkOutput("t3IaddrAfterRedirect", 32'(iaddr), 32'h0FF);
    applyStimulus(1'b1, 1'b0, '0, 8);
    checkPcLog("t3Pc", 0, 32'h3FC);
    checkPcLog("t3Pc", 1, 32'h000);
    checkPcLog("t3Pc", 2, 32'h004);

    // Redirect while streaming; fetch wraps past the top of the PC space
    doReset(1'b1);
    applyStimulus(1'b1, 1'b0, '0, 5);
    applyStimulus(1'b1, 1'b1, 10'h3FC, 1);
    applyStimulus(1'b1, 1'b0, '0, 8);
    expB = '{'h000, 'h004, 'h008, 'h3FC, 'h000, 'h004};
    for (int i = 0; i < 6; i++) checkPcLog("t4Pc", i, 32'(expB[i]));

    // JAL +0x20 at PC 0x010
    rom[4] = JAL_PLUS_20;
    doReset(1'b1);
    applyStimulus(1'b1, 1'b0, '0, 12);
`ifdef IFQ_JAL_PREDICT_EN
    expC = '{'h000, 'h004, 'h008, 'h00C, 'h010, 'h030, 'h034};
    checkPredLog("t5Pred", 4, 32'd1);
`else
    expC = '{'h000, 'h004, 'h008, 'h00C, 'h010, 'h014, 'h018};
    checkPredLog("t5Pred", 4, 32'd0);
`endif
    for (int i = 0; i < 7; i++) checkPcLog("t5Pc", i, 32'(expC[i]));
    checkPredLog("t5Pred", 5, 32'd0);

    // Redirect in the same cycle the JAL word returns: the redirect wins
    doReset(1'b1);
    applyStimulus(1'b1, 1'b0, '0, 5);
    applyStimulus(1'b1, 1'b1, 10'h100, 1);
    applyStimulus(1'b1, 1'b0, '0, 8);
    expA = '{'h000, 'h004, 'h008, 'h100, 'h104};
    for (int i = 0; i < 5; i++) checkPcLog("t6Pc", i, 32'(expA[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
